prog_freq_divider: RTL and testbench
====================================

// Module: prog_freq_divider
// PURPOSE
//   Run-time programmable clock divider with 50% duty cycle for odd and even divisors.
//   Produces a divided clock `out` and a one-cycle `tick` strobe at each rising edge of `out`.
//   Divisor changes are staged and applied only on a period boundary, so no period is truncated.
//   Drives timer and baud-rate logic that needs a selectable low-rate clock.
// PARAMETERS
//   WIDTH        8   bit width of the divisor and the internal counter
//   DEFAULT_DIV  5   divisor loaded at reset; must be in range 2..2^WIDTH-1
// PORTS
//   clk       input   1      system clock; the block uses both clock edges
//   rst       input   1      asynchronous, active-low reset
//   en        input   1      divider enable, sampled on the posedge of clk
//   div_in    input   WIDTH  new divisor value N
//   div_load  input   1      one-cycle request to stage div_in
//   out       output  1      divided clock, period N*Tclk
//   tick      output  1      one-clk pulse in the cycle where out rises
//   div_cur   output  WIDTH  divisor currently in effect
//   err       output  1      one-clk pulse: div_load was rejected because div_in < 2
// BEHAVIOUR
//   Reset (rst=0, asynchronous):
//     - cnt=0, out=0, tick=0, err=0, pending flag=0, div_cur=DEFAULT_DIV.
//     - The negedge stage is also cleared asynchronously.
//   Counter: cnt counts 0..N-1 on posedge; at cnt=N-1 it wraps to 0 (a "wrap" edge).
//   Enable:
//     - The first posedge with en=1 after disable or reset sets cnt=0.
//     - On that same edge out rises and tick=1.
//   Waveform with N = div_cur, measured from the posedge where cnt becomes 0:
//     - out rises at that posedge.
//     - Even N: out falls at the posedge where cnt becomes N/2. High N/2 cycles, low N/2.
//     - Odd N: out falls at the negedge inside cycle cnt=(N-1)/2. High N/2 cycles, low N/2.
//     - out is glitch-free. It is the combination of one posedge flop and one negedge
//       flop, with no combinational path from cnt.
//   tick:
//     - Registered; high for exactly the clk cycle in which cnt=0 while en=1.
//   Divisor load:
//     - div_load=1 with div_in>=2: div_in is written to a pending register and the
//       pending flag is set.
//     - If two loads arrive before a wrap, the last one wins.
//     - The pending value moves to div_cur on the next wrap edge, so the period in
//       progress completes with the old N.
//     - div_load on the same edge as a wrap: the new value applies from the period
//       starting at that edge.
//     - While en=0, a pending or new load updates div_cur on the next posedge.
//     - div_load=1 with div_in<2: nothing is staged, err=1 for one cycle, and div_cur
//       is unchanged.
//   Disable:
//     - en=0 sampled at a posedge: from that edge cnt=0, the posedge flop is 0, tick=0.
//     - The negedge stage clears at the following negedge, so out is low within
//       half a cycle.
//     - A partial high pulse is permitted; no runt pulse follows it.
//   Width rules:
//     - cnt and div_cur are WIDTH bits.
//     - Half-period compare uses N>>1; odd/even is selected by N[0].
//     - Maximum N is 2^WIDTH-1.
//   Reset mid-operation: out goes low immediately; behaviour after release is as at power-up.
// TESTING
//   1. Reset, en=1, N=5, Tclk=10ns -> out period 50ns, high 25ns, tick every 5 cycles.
//   2. Load 4 while en=1 -> current 50ns period finishes, then out is 20ns high / 20ns low.
//   3. N=5, load 7 at cnt=2 -> one full 50ns period, then 70ns periods (35ns high);
//      div_cur reads 7 after the wrap.
//   4. Load 1 -> err pulses for 1 cycle, div_cur and waveform unchanged; load 2 -> 20ns period.
//   5. Drop en at cnt=1 (N=6) -> out low within 5ns. Re-raise en -> out rises on the
//      enabling posedge, tick=1.
//   6. Assert rst mid-high-phase -> out=0 and div_cur=DEFAULT_DIV asynchronously; check N=255.

Source files
------------

// File: rtl/prog_freq_divider.sv
// prog_freq_divider: run-time programmable clock divider with a 50% duty cycle
// for both odd and even divisors.
// - out is the OR of one posedge flop (hi_q) and one negedge flop (neg_q).
// - hi_q covers the whole-cycle part of the high phase.
// - neg_q adds the extra half cycle that odd divisors need.
// - Divisor updates are staged and only take effect on a period boundary.
`timescale 1ns/1ps
module prog_freq_divider #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_load,
   output logic             out,
   output logic             tick,
   output logic [WIDTH-1:0] div_cur,
   output logic             err
);

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic             run_q, run_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             hi_q, hi_d;
   logic             neg_q, neg_d;
   logic             tick_q, tick_d;
   logic             err_q, err_d;
   logic             pend_q, pend_d;
   logic [WIDTH-1:0] pend_val_q, pend_val_d;
   logic [WIDTH-1:0] div_cur_q, div_cur_d;

   logic             load_ok;
   logic             wrap;
   logic             start;
   logic [WIDTH-1:0] next_div;

   // Next-state logic for the posedge domain.
   // - A period starts on the first enabled edge or on a wrap.
   // - The newest accepted divisor is committed at a period start, or at once while disabled.
   always_comb begin
      load_ok    = div_load && (div_in >= MIN_DIV);
      wrap       = run_q && (cnt_q == (div_cur_q - ONE));
      start      = en && (!run_q || wrap);
      next_div   = load_ok ? div_in : (pend_q ? pend_val_q : div_cur_q);

      run_d      = run_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      div_cur_d  = div_cur_q;

      if (!en) begin
         run_d     = 1'b0;
         cnt_d     = '0;
         pend_d    = 1'b0;
         div_cur_d = next_div;
      end else if (start) begin
         run_d     = 1'b1;
         cnt_d     = '0;
         pend_d    = 1'b0;
         div_cur_d = next_div;
      end else begin
         cnt_d = cnt_q + ONE;
         // The last accepted load before the wrap is the one that is kept.
         if (load_ok) begin
            pend_d     = 1'b1;
            pend_val_d = div_in;
         end
      end

      // Whole-cycle high phase.
      // - It covers cycles 0..(N>>1)-1 of the period.
      // - cnt_d=0 always qualifies, because N >= 2.
      hi_d   = run_d && (cnt_d < (div_cur_d >> 1));
      tick_d = start;
      err_d  = div_load && (div_in < MIN_DIV);
   end

   // The negedge stage copies hi_q for odd divisors only.
   // This stretches the high phase by half a clock.
   always_comb begin
      neg_d = hi_q & div_cur_q[0];
   end

   // Posedge state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q      <= 1'b0;
         cnt_q      <= '0;
         hi_q       <= 1'b0;
         tick_q     <= 1'b0;
         err_q      <= 1'b0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         div_cur_q  <= DEF_DIV;
      end else begin
         run_q      <= run_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         tick_q     <= tick_d;
         err_q      <= err_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         div_cur_q  <= div_cur_d;
      end
   end

   // Negedge half-cycle extension flop, cleared with the rest of the block.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         neg_q <= 1'b0;
      end else begin
         neg_q <= neg_d;
      end
   end

   // out is the OR of two flops.
   // - neg_q only rises while hi_q is already high.
   // - hi_q only falls while neg_q holds the level.
   // So the OR cannot glitch.
   assign out     = hi_q | neg_q;
   assign tick    = tick_q;
   assign err     = err_q;
   assign div_cur = div_cur_q;

endmodule

// File: tb/tb_prog_freq_divider.sv
// Self-checking bench for prog_freq_divider.
// - A period-level model predicts the outputs at every posedge and every negedge.
// - Measured out high/period times pin the model against hand-computed values.
`timescale 1ns/1ps
module tb_prog_freq_divider;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] div_in;
   logic       div_load;
   logic       out;
   logic       tick;
   logic [7:0] div_cur;
   logic       err;

   int checks = 0;
   int errors = 0;

   // Model state: whether a period is running, cycle index inside it,
   // the divisor in force, and the staged divisor.
   int m_run, m_ph, m_cur, m_pend, m_pval, m_tick, m_err;
   bit skip_pos;

   longint t_rise  = -1;
   longint hi_ns   = 0;
   longint per_ns  = 0;

   prog_freq_divider #(.WIDTH(8), .DEFAULT_DIV(5)) dut (
      .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
      .out(out), .tick(tick), .div_cur(div_cur), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Measure the divided clock in ns.
   always @(posedge out) begin
      if (t_rise >= 0) per_ns = $time - t_rise;
      t_rise = $time;
   end
   always @(negedge out) begin
      if (t_rise >= 0) hi_ns = $time - t_rise;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_ph = 0; m_cur = 5; m_pend = 0; m_pval = 0; m_tick = 0; m_err = 0;
      skip_pos = 0;
   endtask

   // One clock: drive the inputs, then advance the model at the posedge.
   // Outputs are compared after the posedge and again after the negedge.
   // Out is high for the first N half-cycles of each period.
   task automatic step(input bit e, input bit ld, input int d);
      int was_run;
      bit valid;
      en = e; div_load = ld; div_in = 8'(d);
      @(posedge clk);
      was_run = m_run;
      valid   = ld && d >= 2;
      m_err   = (ld && d < 2) ? 1 : 0;
      if (!e) begin
         if (valid) m_cur = d; else if (m_pend != 0) m_cur = m_pval;
         m_pend = 0; m_run = 0; m_ph = 0; m_tick = 0;
      end else if (m_run == 0 || m_ph == m_cur - 1) begin
         if (valid) m_cur = d; else if (m_pend != 0) m_cur = m_pval;
         m_pend = 0; m_run = 1; m_ph = 0; m_tick = 1;
      end else begin
         if (valid) begin m_pend = 1; m_pval = d; end
         m_ph++; m_tick = 0;
      end
      skip_pos = (!e && was_run != 0);
      #1;
      chk("tick", tick, m_tick);
      chk("err", err, m_err);
      chk("div_cur", div_cur, m_cur);
      if (!skip_pos) chk("out_pos", out, (m_run != 0 && 2 * m_ph < m_cur) ? 1 : 0);
      @(negedge clk);
      #1;
      chk("out_neg", out, (m_run != 0 && 2 * m_ph + 1 < m_cur) ? 1 : 0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0);
   endtask

   // Advance with en=1 until the model reaches the wanted cycle index and divisor.
   task automatic wait_for(input int ph, input int cur);
      int k;
      k = 0;
      while (!(m_run != 0 && m_ph == ph && m_cur == cur) && k < 700) begin
         step(1, 0, 0);
         k++;
      end
      if (k >= 700) chk("wait_timeout", 1, 0);
   endtask

   // Assert reset between clock edges and check the asynchronous response.
   task automatic async_reset();
      #2 rst = 1'b0;
      #1;
      chk("rst_out", out, 0);
      chk("rst_tick", tick, 0);
      chk("rst_err", err, 0);
      chk("rst_div_cur", div_cur, 5);
      model_reset();
      @(negedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0;
      model_reset();
      #1;
      async_reset();

      // N=5: 50 ns period, 25 ns high, tick every 5 cycles.
      begin
         int ticks;
         ticks = 0;
         for (int i = 0; i < 15; i++) begin
            step(1, 0, 0);
            if (tick) ticks++;
         end
         chk("n5_ticks", ticks, 3);
         run(6);
         chk("n5_high_ns", hi_ns, 25);
         chk("n5_period_ns", per_ns, 50);
      end

      // Load 4 mid-period: the current 50 ns period completes first.
      wait_for(1, 5);
      step(1, 1, 4);
      wait_for(0, 4);
      chk("n4_last_old_period", per_ns, 50);
      run(10);
      chk("n4_high_ns", hi_ns, 20);
      chk("n4_period_ns", per_ns, 40);

      // Back to N=5, then load 7 at cnt=2.
      step(1, 1, 5);
      wait_for(0, 5);
      run(6);
      wait_for(2, 5);
      step(1, 1, 7);
      chk("n7_staged_div_cur", div_cur, 5);
      wait_for(0, 7);
      chk("n7_old_period", per_ns, 50);
      chk("n7_div_cur", div_cur, 7);
      run(15);
      chk("n7_high_ns", hi_ns, 35);
      chk("n7_period_ns", per_ns, 70);

      // A rejected load leaves everything unchanged; N=2 gives a 20 ns period.
      step(1, 1, 1);
      chk("bad_load_err", err, 1);
      chk("bad_load_div_cur", div_cur, 7);
      step(1, 0, 0);
      chk("bad_load_err_clear", err, 0);
      step(1, 1, 2);
      wait_for(0, 2);
      run(4);
      chk("n2_period_ns", per_ns, 20);
      chk("n2_high_ns", hi_ns, 10);

      // N=6: drop en at cnt=1, then re-enable.
      step(1, 1, 6);
      wait_for(1, 6);
      step(0, 0, 0);
      chk("dis_out_low", out, 0);
      step(0, 0, 0);
      step(1, 0, 0);
      chk("reen_tick", tick, 1);
      chk("reen_out", out, 1);
      run(8);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bit e, ld;
         int d;
         e  = ($urandom_range(0, 11) != 0);
         ld = ($urandom_range(0, 6) == 0);
         d  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
         step(e, ld, d);
      end

      // Reset while out is high, then check the largest divisor.
      step(0, 0, 0);
      step(1, 1, 9);
      wait_for(0, 9);
      async_reset();
      step(1, 1, 255);
      wait_for(0, 255);
      run(520);
      chk("n255_high_ns", hi_ns, 1275);
      chk("n255_period_ns", per_ns, 2550);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
